// File: rtl/serv_bufreg2_arst.sv
// serv_bufreg2_arst: SERV second buffer register (store shift-in, load serial-out, shift-amount down-counter)
module serv_bufreg2_arst (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_init,
    input  logic        i_cnt_done,
    input  logic [1:0]  i_lsb,
    input  logic        i_byte_valid,
    output logic        o_sh_done,
    output logic        o_sh_done_r,
    input  logic        i_op_b_sel,
    input  logic        i_shift_op,
    input  logic        i_rs2,
    input  logic        i_imm,
    output logic        o_op_b,
    output logic        o_q,
    output logic [31:0] o_dat,
    input  logic        i_load,
    input  logic [31:0] i_dat
);
    logic [31:0] dat_q, dat_d;
    logic [5:0]  shamt;
    // Bits [29:24] double as the shift counter; bit 29 is cleared at the end of the init phase of a shift
    always_comb begin
        o_op_b = i_op_b_sel ? i_rs2 : i_imm;
        shamt  = (i_shift_op & !i_init) ? dat_q[29:24] - 6'd1
                                        : {dat_q[30] & !(i_shift_op & i_cnt_done), dat_q[29:25]};
        dat_d  = i_load ? i_dat
               : (i_shift_op | (i_en & i_byte_valid)) ? {o_op_b, dat_q[31], shamt, dat_q[24:1]}
               : dat_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) dat_q <= '0;
        else          dat_q <= dat_d;
    end
    assign o_sh_done   = shamt[5];
    assign o_sh_done_r = dat_q[29];
    assign o_q         = dat_q[{i_lsb, 3'b000}];
    assign o_dat       = dat_q;
endmodule

// File: tb/tb_serv_bufreg2_arst.sv
// tb_serv_bufreg2_arst: directed bench with an expected-value queue for o_dat after each clock
module tb_serv_bufreg2_arst;
    logic        clk = 0, rst_n = 0;
    logic        en = 0, init = 0, cnt_done = 0, byte_valid = 0;
    logic [1:0]  lsb = 0;
    logic        sh_done, sh_done_r;
    logic        op_b_sel = 0, shift_op = 0, rs2 = 0, imm = 0;
    logic        op_b, q;
    logic [31:0] dat;
    logic        load = 0;
    logic [31:0] din = 0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    serv_bufreg2_arst dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_lsb(lsb), .i_byte_valid(byte_valid), .o_sh_done(sh_done), .o_sh_done_r(sh_done_r),
        .i_op_b_sel(op_b_sel), .i_shift_op(shift_op), .i_rs2(rs2), .i_imm(imm),
        .o_op_b(op_b), .o_q(q), .o_dat(dat), .i_load(load), .i_dat(din)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clock_and_check(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), dat, exp_q.pop_front());
    endtask

    task automatic idle();
        en = 0; init = 0; cnt_done = 0; byte_valid = 0; shift_op = 0;
        load = 0; op_b_sel = 0; rs2 = 0; imm = 0;
    endtask

    initial begin
        #12;
        check("reset_dat", dat, 32'h0);
        check("reset_q", {31'h0, q}, 32'h0);
        check("reset_shr", {31'h0, sh_done_r}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        op_b_sel = 1; rs2 = 1; imm = 0;
        #1 check("opb_rs2", {31'h0, op_b}, 32'h1);
        op_b_sel = 0;
        #1 check("opb_imm", {31'h0, op_b}, 32'h0);
        shift_op = 1;
        #1 check("shdone_zero", {31'h0, sh_done}, 32'h1);
        init = 1;
        #1 check("shdone_init", {31'h0, sh_done}, 32'h0);
        idle();

        load = 1; din = 32'hAABBCCDD;
        clock_and_check("load", 32'hAABBCCDD);
        load = 0;
        for (int i = 0; i < 4; i++) begin
            lsb = 2'(i);
            #1 check($sformatf("q_lane%0d", i), {31'h0, q}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        lsb = 0;

        load = 1; din = 32'h12345678; shift_op = 1; en = 1; byte_valid = 1; op_b_sel = 1; rs2 = 1;
        clock_and_check("load_prio", 32'h12345678);
        idle();

        #2 rst_n = 0;
        #1;
        check("arst_dat", dat, 32'h0);
        check("arst_q", {31'h0, q}, 32'h0);
        check("arst_shr", {31'h0, sh_done_r}, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        en = 1; byte_valid = 1; op_b_sel = 1; rs2 = 1;
        clock_and_check("fill_rs2_1", 32'h80000000);
        for (int i = 1; i < 31; i++) clock_and_check("fill_rs2_mid", ~(32'hFFFFFFFF >> (i + 1)));
        clock_and_check("fill_rs2", 32'hFFFFFFFF);
        idle();

        rst_n = 0; #1 rst_n = 1;
        en = 1; byte_valid = 1; op_b_sel = 0; imm = 1; rs2 = 0;
        for (int i = 0; i < 31; i++) clock_and_check("fill_imm_mid", ~(32'hFFFFFFFF >> (i + 1)));
        clock_and_check("fill_imm", 32'hFFFFFFFF);
        idle();

        load = 1; din = 32'h5A5A5A5A;
        clock_and_check("hold_load", 32'h5A5A5A5A);
        load = 0; en = 0; byte_valid = 1; op_b_sel = 1; rs2 = 1;
        for (int i = 0; i < 5; i++) clock_and_check("hold_en0", 32'h5A5A5A5A);
        en = 1; byte_valid = 0;
        for (int i = 0; i < 5; i++) clock_and_check("hold_bv0", 32'h5A5A5A5A);
        idle();

        load = 1; din = 32'h40000000;
        clock_and_check("cd_load", 32'h40000000);
        load = 0; shift_op = 1; init = 1; cnt_done = 1;
        clock_and_check("cnt_done_clr", 32'h00000000);
        load = 1; shift_op = 0; init = 0; cnt_done = 0;
        clock_and_check("cd_load2", 32'h40000000);
        load = 0; shift_op = 1; init = 1;
        clock_and_check("init_shift", 32'h20000000);
        idle();

        load = 1; din = 32'h03000000;
        clock_and_check("cnt_load", 32'h03000000);
        load = 0; shift_op = 1; init = 0;
        clock_and_check("cnt_2", 32'h02800000);
        check("cnt_2_done", {31'h0, sh_done}, 32'h0);
        clock_and_check("cnt_1", 32'h01400000);
        check("cnt_1_done", {31'h0, sh_done}, 32'h0);
        clock_and_check("cnt_0", 32'h00A00000);
        check("cnt_0_done", {31'h0, sh_done}, 32'h1);
        check("cnt_0_done_r", {31'h0, sh_done_r}, 32'h0);
        clock_and_check("cnt_wrap", 32'h3F500000);
        check("cnt_wrap_done_r", {31'h0, sh_done_r}, 32'h1);
        idle();

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_left observed=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
